// File: rtl/piso_serializer_8_bits.sv
// Parallel-in serial-out serializer with valid/ready load handshake and gapless back-to-back frames.
// Optional even-parity bit after the data bits when PISO_PARITY_EN is defined.
module piso_serializer_8_bits #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int LSB_FIRST    = 1
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
    input  logic                  Load_Valid_In,
    output logic                  Load_Ready_Out,
    output logic                  Serial_Data_Out,
    output logic                  Serial_Valid_Out,
    output logic                  Frame_Done_Out,
    output logic                  Busy_Out
);

`ifdef PISO_PARITY_EN
    localparam int FRAME_BITS = DATA_WIDTH + 1;
`else
    localparam int FRAME_BITS = DATA_WIDTH;
`endif
    localparam int BIT_CNT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int CYC_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_BITS - 1);
    localparam logic [CYC_CNT_W-1:0] CYC_LAST = CYC_CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CYC_CNT_W-1:0]    cyc_cnt_q, cyc_cnt_d;
    logic                    serial_data_q, serial_data_d;
    logic                    serial_valid_q, serial_valid_d;
    logic                    frame_done_q, frame_done_d;
`ifdef PISO_PARITY_EN
    logic                    parity_q, parity_d;
`endif
    logic                    load_ready;
    logic                    accept;
    logic                    next_bit;

    // Ready early on the final cycle of a frame so the next word can follow without a gap.
    assign load_ready = (state_q == IDLE) || ((bit_cnt_q == BIT_LAST) && (cyc_cnt_q == CYC_LAST));
    assign accept     = Load_Valid_In && load_ready;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        cyc_cnt_d = cyc_cnt_q;
`ifdef PISO_PARITY_EN
        parity_d  = parity_q;
`endif
        if (accept) begin
            state_d   = SHIFT;
            shift_d   = Parallel_Data_In;
            bit_cnt_d = '0;
            cyc_cnt_d = '0;
`ifdef PISO_PARITY_EN
            parity_d  = ^Parallel_Data_In;
`endif
        end else if (state_q == SHIFT) begin
            if (cyc_cnt_q == CYC_LAST) begin
                cyc_cnt_d = '0;
                if (bit_cnt_q == BIT_LAST) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (LSB_FIRST != 0) begin
                        shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
                    end else begin
                        shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end else begin
                cyc_cnt_d = cyc_cnt_q + CYC_CNT_W'(1);
            end
        end
    end

    // Outputs are registered from the next-state values so they line up with the bit being held.
    always_comb begin
        if (LSB_FIRST != 0) begin
            next_bit = shift_d[0];
        end else begin
            next_bit = shift_d[DATA_WIDTH-1];
        end
`ifdef PISO_PARITY_EN
        if (bit_cnt_d == BIT_LAST) begin
            next_bit = parity_d;
        end
`endif
        serial_valid_d = (state_d == SHIFT);
        serial_data_d  = (state_d == SHIFT) ? next_bit : 1'b0;
        frame_done_d   = (state_d == SHIFT) && (bit_cnt_d == BIT_LAST) && (cyc_cnt_d == CYC_LAST);
    end

    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            state_q        <= IDLE;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            cyc_cnt_q      <= '0;
            serial_data_q  <= 1'b0;
            serial_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q       <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            cyc_cnt_q      <= cyc_cnt_d;
            serial_data_q  <= serial_data_d;
            serial_valid_q <= serial_valid_d;
            frame_done_q   <= frame_done_d;
`ifdef PISO_PARITY_EN
            parity_q       <= parity_d;
`endif
        end
    end

    assign Load_Ready_Out   = load_ready;
    assign Serial_Data_Out  = serial_data_q;
    assign Serial_Valid_Out = serial_valid_q;
    assign Frame_Done_Out   = frame_done_q;
    assign Busy_Out         = (state_q == SHIFT);

endmodule

// File: tb/tb_piso_serializer_8_bits.sv
// Directed self-checking bench for piso_serializer_8_bits: default LSB-first instance plus an
// MSB-first, 3-clocks-per-bit instance; expectations follow PISO_PARITY_EN when it is defined.
module tb_piso_serializer_8_bits;

`ifdef PISO_PARITY_EN
    localparam int FB = 9;
`else
    localparam int FB = 8;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] d_data = 8'h00;
    logic       d_valid = 1'b0;
    logic       d_ready, d_sdata, d_svalid, d_done, d_busy;
    logic [7:0] m_data = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ready, m_sdata, m_svalid, m_done, m_busy;
    logic [7:0] sipo = 8'h00;
    int         tests_run = 0;
    int         tests_failed = 0;

    always #5 clk = ~clk;

    piso_serializer_8_bits dut (
        .Clk_In           (clk),
        .Reset_In         (reset),
        .Parallel_Data_In (d_data),
        .Load_Valid_In    (d_valid),
        .Load_Ready_Out   (d_ready),
        .Serial_Data_Out  (d_sdata),
        .Serial_Valid_Out (d_svalid),
        .Frame_Done_Out   (d_done),
        .Busy_Out         (d_busy)
    );

    piso_serializer_8_bits #(
        .DATA_WIDTH   (8),
        .CLKS_PER_BIT (3),
        .LSB_FIRST    (0)
    ) dut_msb (
        .Clk_In           (clk),
        .Reset_In         (reset),
        .Parallel_Data_In (m_data),
        .Load_Valid_In    (m_valid),
        .Load_Ready_Out   (m_ready),
        .Serial_Data_Out  (m_sdata),
        .Serial_Valid_Out (m_svalid),
        .Frame_Done_Out   (m_done),
        .Busy_Out         (m_busy)
    );

    // Downstream SIPO model: shifts in at bit 7 on the falling edge.
    always @(negedge clk) begin
        if (reset) sipo <= 8'h00;
        else if (d_svalid) sipo <= {d_sdata, sipo[7:1]};
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic expBit(input logic [7:0] word, input int idx, input bit lsb);
        if (idx >= 8) return ^word;
        return lsb ? word[idx] : word[7-idx];
    endfunction

    task automatic applyStimulus(input logic [7:0] word);
        d_data  = word;
        d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_valid"}, d_svalid, 1'b0);
        checkOutput({tag, "_data"},  d_sdata,  1'b0);
        checkOutput({tag, "_done"},  d_done,   1'b0);
        checkOutput({tag, "_ready"}, d_ready,  1'b1);
        checkOutput({tag, "_busy"},  d_busy,   1'b0);
    endtask

    // Walks one frame on the default instance; Load_Valid_In is left to the caller.
    task automatic checkFrame(input string tag, input logic [7:0] word);
        for (int i = 0; i < FB; i++) begin
            checkOutput($sformatf("%s_bit%0d", tag, i), d_sdata, expBit(word, i, 1'b1));
            checkOutput($sformatf("%s_valid%0d", tag, i), d_svalid, 1'b1);
            checkOutput($sformatf("%s_done%0d", tag, i), d_done, (i == FB - 1));
            checkOutput($sformatf("%s_ready%0d", tag, i), d_ready, (i == FB - 1));
            checkOutput($sformatf("%s_busy%0d", tag, i), d_busy, 1'b1);
            tick();
        end
`ifndef PISO_PARITY_EN
        checkOutput({tag, "_sipo"}, sipo, word);
`endif
    endtask

    initial begin
        // Test 1: reset held two cycles
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checkIdle("reset");
        checkOutput("reset_msb_ready", m_ready, 1'b1);
        checkOutput("reset_msb_valid", m_svalid, 1'b0);
        tick();
        checkIdle("idle");

        // Test 2: single frame 0xA5
        applyStimulus(8'hA5);
        checkFrame("a5", 8'hA5);
        checkIdle("a5_after");

        // Test 3: 0x3C then 0xFF held valid during the frame, accepted only at the frame end
        applyStimulus(8'h3C);
        d_data  = 8'hFF;
        d_valid = 1'b1;
        checkFrame("3c", 8'h3C);
        d_valid = 1'b0;
        d_data  = 8'h00;
        checkFrame("ff", 8'hFF);
        checkIdle("ff_after");

        // Parity case and another pattern
        applyStimulus(8'h07);
        checkFrame("07", 8'h07);
        checkIdle("07_after");

        // Test 4: MSB-first, three clocks per bit, 0x81
        m_data  = 8'h81;
        m_valid = 1'b1;
        tick();
        m_valid = 1'b0;
        m_data  = 8'h00;
        for (int b = 0; b < FB; b++) begin
            for (int c = 0; c < 3; c++) begin
                checkOutput($sformatf("msb_bit%0d_%0d", b, c), m_sdata, expBit(8'h81, b, 1'b0));
                checkOutput($sformatf("msb_valid%0d_%0d", b, c), m_svalid, 1'b1);
                checkOutput($sformatf("msb_done%0d_%0d", b, c), m_done, (b == FB - 1) && (c == 2));
                checkOutput($sformatf("msb_ready%0d_%0d", b, c), m_ready, (b == FB - 1) && (c == 2));
                tick();
            end
        end
        checkOutput("msb_after_valid", m_svalid, 1'b0);
        checkOutput("msb_after_busy", m_busy, 1'b0);
        checkOutput("msb_after_ready", m_ready, 1'b1);

        // Test 5: reset during the 4th bit of 0xF0, with a competing load request
        applyStimulus(8'hF0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("f0_bit%0d", i), d_sdata, expBit(8'hF0, i, 1'b1));
            tick();
        end
        checkOutput("f0_bit3_valid", d_svalid, 1'b1);
        reset   = 1'b1;
        d_data  = 8'h55;
        d_valid = 1'b1;
        tick();
        reset   = 1'b0;
        d_valid = 1'b0;
        checkIdle("abort");
        tick();
        checkIdle("abort_idle");
        applyStimulus(8'h0F);
        checkFrame("0f", 8'h0F);
        checkIdle("0f_after");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
